// File: rtl/riscv_core_dcache_pkg.sv
// rtl/riscv_core_dcache_pkg.sv - shared FSM states and AXI constants for the dcache AXI bridge
package riscv_core_dcache_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_WR_REQ,
        ST_WR_RESP,
        ST_DONE
    } state_t;

    localparam logic [1:0] AXI_RESP_OKAY    = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR   = 2'b01;
    localparam logic [2:0] AXI_SIZE_32B     = 3'b101;
    localparam int         LINE_OFFSET_BITS = 5;

endpackage

// File: rtl/riscv_core_dcache_wlane_align.sv
// rtl/riscv_core_dcache_wlane_align.sv - places a 64-bit store into its lane of a 256-bit AXI beat
module riscv_core_dcache_wlane_align
    import riscv_core_dcache_pkg::*;
#(
    parameter int CORE_DATA_WIDTH = 64,
    parameter int AXI_DATA_WIDTH  = 256
) (
    input  logic [1:0]                   lane,
    input  logic [CORE_DATA_WIDTH-1:0]   data,
    input  logic [CORE_DATA_WIDTH/8-1:0] strobe,
    output logic [AXI_DATA_WIDTH-1:0]    wdata,
    output logic [AXI_DATA_WIDTH/8-1:0]  wstrb
);

    localparam int LANES      = AXI_DATA_WIDTH / CORE_DATA_WIDTH;
    localparam int PAD_STROBE = AXI_DATA_WIDTH / 8 - CORE_DATA_WIDTH / 8;

    // Data goes to every lane; only the strobes select the addressed one.
    assign wdata = {LANES{data}};
    assign wstrb = {{PAD_STROBE{1'b0}}, strobe} << {lane, 3'b000};

endmodule

// File: rtl/riscv_core_dcache_axi_bridge.sv
// rtl/riscv_core_dcache_axi_bridge.sv - dcache line-fill / write-through requests to single-beat AXI4
module riscv_core_dcache_axi_bridge
    import riscv_core_dcache_pkg::*;
#(
    parameter int ADDR_WIDTH      = 64,
    parameter int CORE_DATA_WIDTH = 64,
    parameter int AXI_DATA_WIDTH  = 256,
    parameter int AXI_ID_WIDTH    = 4,
    parameter int AXI_ID          = 0
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_mem_read_req,
    input  logic [ADDR_WIDTH-1:0]       i_mem_read_address,
    output logic                        o_mem_read_done,
    output logic [AXI_DATA_WIDTH-1:0]   o_mem_read_data,
    input  logic                        i_mem_write_valid,
    input  logic [ADDR_WIDTH-1:0]       i_mem_write_address,
    input  logic [CORE_DATA_WIDTH-1:0]  i_mem_write_data,
    input  logic [7:0]                  i_mem_write_strobe,
    output logic                        o_mem_write_done,
    output logic                        o_bus_error,
    output logic                        m_axi_arvalid,
    input  logic                        m_axi_arready,
    output logic [ADDR_WIDTH-1:0]       m_axi_araddr,
    output logic [AXI_ID_WIDTH-1:0]     m_axi_arid,
    output logic [7:0]                  m_axi_arlen,
    output logic [2:0]                  m_axi_arsize,
    output logic [1:0]                  m_axi_arburst,
    input  logic                        m_axi_rvalid,
    output logic                        m_axi_rready,
    input  logic [AXI_DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]                  m_axi_rresp,
    input  logic                        m_axi_rlast,
    output logic                        m_axi_awvalid,
    input  logic                        m_axi_awready,
    output logic [ADDR_WIDTH-1:0]       m_axi_awaddr,
    output logic [AXI_ID_WIDTH-1:0]     m_axi_awid,
    output logic [7:0]                  m_axi_awlen,
    output logic [2:0]                  m_axi_awsize,
    output logic [1:0]                  m_axi_awburst,
    output logic                        m_axi_wvalid,
    input  logic                        m_axi_wready,
    output logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                        m_axi_wlast,
    input  logic                        m_axi_bvalid,
    output logic                        m_axi_bready,
    input  logic [1:0]                  m_axi_bresp
);

    state_t                      state;
    state_t                      state_next;
    logic [ADDR_WIDTH-1:0]       addr_q;
    logic [CORE_DATA_WIDTH-1:0]  data_q;
    logic [7:0]                  strb_q;
    logic                        op_write;
    logic                        err_q;
    logic                        aw_done;
    logic                        w_done;
    logic [AXI_DATA_WIDTH-1:0]   rdata_q;
    logic [ADDR_WIDTH-1:0]       line_addr;
    logic                        unused_bits;

    assign line_addr   = {addr_q[ADDR_WIDTH-1:LINE_OFFSET_BITS], {LINE_OFFSET_BITS{1'b0}}};
    assign unused_bits = ^{m_axi_rlast, addr_q[2:0]};

    assign m_axi_araddr  = line_addr;
    assign m_axi_arid    = AXI_ID_WIDTH'(AXI_ID);
    assign m_axi_arlen   = 8'd0;
    assign m_axi_arsize  = AXI_SIZE_32B;
    assign m_axi_arburst = AXI_BURST_INCR;
    assign m_axi_awaddr  = line_addr;
    assign m_axi_awid    = AXI_ID_WIDTH'(AXI_ID);
    assign m_axi_awlen   = 8'd0;
    assign m_axi_awsize  = AXI_SIZE_32B;
    assign m_axi_awburst = AXI_BURST_INCR;
    assign m_axi_wlast   = 1'b1;
    assign o_mem_read_data = rdata_q;

    riscv_core_dcache_wlane_align #(
        .CORE_DATA_WIDTH (CORE_DATA_WIDTH),
        .AXI_DATA_WIDTH  (AXI_DATA_WIDTH)
    ) u_wlane_align (
        .lane   (addr_q[LINE_OFFSET_BITS-1:3]),
        .data   (data_q),
        .strobe (strb_q),
        .wdata  (m_axi_wdata),
        .wstrb  (m_axi_wstrb)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= ST_IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next       = state;
        m_axi_arvalid    = 1'b0;
        m_axi_rready     = 1'b0;
        m_axi_awvalid    = 1'b0;
        m_axi_wvalid     = 1'b0;
        m_axi_bready     = 1'b0;
        o_mem_read_done  = 1'b0;
        o_mem_write_done = 1'b0;
        o_bus_error      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_mem_read_req)         state_next = ST_RD_ADDR;
                else if (i_mem_write_valid) state_next = ST_WR_REQ;
            end
            ST_RD_ADDR: begin
                m_axi_arvalid = 1'b1;
                if (m_axi_arready) state_next = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                m_axi_rready = 1'b1;
                if (m_axi_rvalid) state_next = ST_RD_DATA == state ? ST_DONE : state;
            end
            ST_WR_REQ: begin
                // AW and W complete independently; leave only once both have handshaken.
                m_axi_awvalid = !aw_done;
                m_axi_wvalid  = !w_done;
                if ((aw_done || m_axi_awready) && (w_done || m_axi_wready)) state_next = ST_WR_RESP;
            end
            ST_WR_RESP: begin
                m_axi_bready = 1'b1;
                if (m_axi_bvalid) state_next = ST_DONE;
            end
            ST_DONE: begin
                o_mem_read_done  = !op_write;
                o_mem_write_done = op_write;
                o_bus_error      = err_q;
                state_next       = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            addr_q   <= '0;
            data_q   <= '0;
            strb_q   <= '0;
            op_write <= 1'b0;
            err_q    <= 1'b0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            rdata_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    aw_done <= 1'b0;
                    w_done  <= 1'b0;
                    err_q   <= 1'b0;
                    if (i_mem_read_req) begin
                        addr_q   <= i_mem_read_address;
                        op_write <= 1'b0;
                    end else if (i_mem_write_valid) begin
                        addr_q   <= i_mem_write_address;
                        data_q   <= i_mem_write_data;
                        strb_q   <= i_mem_write_strobe;
                        op_write <= 1'b1;
                    end
                end
                ST_RD_DATA: begin
                    if (m_axi_rvalid) begin
                        rdata_q <= m_axi_rdata;
                        err_q   <= (m_axi_rresp != AXI_RESP_OKAY);
                    end
                end
                ST_WR_REQ: begin
                    if (m_axi_awready) aw_done <= 1'b1;
                    if (m_axi_wready)  w_done  <= 1'b1;
                end
                ST_WR_RESP: begin
                    if (m_axi_bvalid) err_q <= (m_axi_bresp != AXI_RESP_OKAY);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_core_dcache_axi_bridge.sv
// tb/tb_riscv_core_dcache_axi_bridge.sv - self-checking bench for riscv_core_dcache_axi_bridge
module tb_riscv_core_dcache_axi_bridge;

    logic         i_clk;
    logic         i_rst_n;
    logic         i_mem_read_req;
    logic [63:0]  i_mem_read_address;
    logic         o_mem_read_done;
    logic [255:0] o_mem_read_data;
    logic         i_mem_write_valid;
    logic [63:0]  i_mem_write_address;
    logic [63:0]  i_mem_write_data;
    logic [7:0]   i_mem_write_strobe;
    logic         o_mem_write_done;
    logic         o_bus_error;
    logic         m_axi_arvalid, m_axi_arready;
    logic [63:0]  m_axi_araddr;
    logic [3:0]   m_axi_arid;
    logic [7:0]   m_axi_arlen;
    logic [2:0]   m_axi_arsize;
    logic [1:0]   m_axi_arburst;
    logic         m_axi_rvalid, m_axi_rready;
    logic [255:0] m_axi_rdata;
    logic [1:0]   m_axi_rresp;
    logic         m_axi_rlast;
    logic         m_axi_awvalid, m_axi_awready;
    logic [63:0]  m_axi_awaddr;
    logic [3:0]   m_axi_awid;
    logic [7:0]   m_axi_awlen;
    logic [2:0]   m_axi_awsize;
    logic [1:0]   m_axi_awburst;
    logic         m_axi_wvalid, m_axi_wready;
    logic [255:0] m_axi_wdata;
    logic [31:0]  m_axi_wstrb;
    logic         m_axi_wlast;
    logic         m_axi_bvalid, m_axi_bready;
    logic [1:0]   m_axi_bresp;

    riscv_core_dcache_axi_bridge dut (
        .i_clk (i_clk), .i_rst_n (i_rst_n),
        .i_mem_read_req (i_mem_read_req), .i_mem_read_address (i_mem_read_address),
        .o_mem_read_done (o_mem_read_done), .o_mem_read_data (o_mem_read_data),
        .i_mem_write_valid (i_mem_write_valid), .i_mem_write_address (i_mem_write_address),
        .i_mem_write_data (i_mem_write_data), .i_mem_write_strobe (i_mem_write_strobe),
        .o_mem_write_done (o_mem_write_done), .o_bus_error (o_bus_error),
        .m_axi_arvalid (m_axi_arvalid), .m_axi_arready (m_axi_arready), .m_axi_araddr (m_axi_araddr),
        .m_axi_arid (m_axi_arid), .m_axi_arlen (m_axi_arlen), .m_axi_arsize (m_axi_arsize),
        .m_axi_arburst (m_axi_arburst), .m_axi_rvalid (m_axi_rvalid), .m_axi_rready (m_axi_rready),
        .m_axi_rdata (m_axi_rdata), .m_axi_rresp (m_axi_rresp), .m_axi_rlast (m_axi_rlast),
        .m_axi_awvalid (m_axi_awvalid), .m_axi_awready (m_axi_awready), .m_axi_awaddr (m_axi_awaddr),
        .m_axi_awid (m_axi_awid), .m_axi_awlen (m_axi_awlen), .m_axi_awsize (m_axi_awsize),
        .m_axi_awburst (m_axi_awburst), .m_axi_wvalid (m_axi_wvalid), .m_axi_wready (m_axi_wready),
        .m_axi_wdata (m_axi_wdata), .m_axi_wstrb (m_axi_wstrb), .m_axi_wlast (m_axi_wlast),
        .m_axi_bvalid (m_axi_bvalid), .m_axi_bready (m_axi_bready), .m_axi_bresp (m_axi_bresp)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_errors = 0;

    // Slave model configuration and state
    int           ar_delay, r_delay, aw_delay, w_delay, b_delay;
    logic [1:0]   rresp_cfg, bresp_cfg;
    logic [255:0] rdata_cfg;
    bit           r_pending, b_pending, aw_got, w_got;
    int           ar_wait, r_wait, aw_wait, w_wait, b_wait;

    // Observation log
    int           done_kind[$];
    int           done_cyc[$];
    logic         done_err[$];
    int           ar_hs, aw_hs, w_hs, extra, stray, both;
    logic [63:0]  cap_araddr, cap_awaddr;
    logic [255:0] cap_wdata, cap_rdata;
    logic [31:0]  cap_wstrb;
    logic [7:0]   cap_arlen, cap_awlen;
    logic [2:0]   cap_arsize, cap_awsize;
    logic [1:0]   cap_arburst, cap_awburst;
    logic [3:0]   cap_arid, cap_awid;
    logic         cap_wlast;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_slave();
        m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = '0; m_axi_rresp = 0; m_axi_rlast = 0;
        m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 0;
        r_pending = 0; b_pending = 0; aw_got = 0; w_got = 0;
        ar_wait = 0; r_wait = 0; aw_wait = 0; w_wait = 0; b_wait = 0;
    endtask

    task automatic clear_log();
        done_kind.delete(); done_cyc.delete(); done_err.delete();
        ar_hs = 0; aw_hs = 0; w_hs = 0; extra = 0; stray = 0; both = 0;
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    // Acts as the AXI slave each cycle; returns after n_done done pulses (or max_cyc cycles)
    task automatic serve(input int n_done, input int max_cyc, input string tag);
        int seen;
        seen = 0;
        for (int c = 1; c <= max_cyc && seen < n_done; c++) begin
            @(negedge i_clk);
            m_axi_rvalid = 0;
            if (r_pending) begin
                if (r_wait >= r_delay) begin
                    m_axi_rvalid = 1; m_axi_rdata = rdata_cfg; m_axi_rresp = rresp_cfg; m_axi_rlast = 1;
                    if (m_axi_rready) r_pending = 0;
                end else r_wait++;
            end
            m_axi_bvalid = 0;
            if (b_pending) begin
                if (b_wait >= b_delay) begin
                    m_axi_bvalid = 1; m_axi_bresp = bresp_cfg;
                    if (m_axi_bready) b_pending = 0;
                end else b_wait++;
            end
            m_axi_arready = 0;
            if (m_axi_arvalid) begin
                if (ar_wait >= ar_delay) begin
                    m_axi_arready = 1; ar_hs++; ar_wait = 0; r_pending = 1; r_wait = 0;
                    cap_araddr = m_axi_araddr; cap_arlen = m_axi_arlen; cap_arsize = m_axi_arsize;
                    cap_arburst = m_axi_arburst; cap_arid = m_axi_arid;
                end else ar_wait++;
            end
            m_axi_awready = 0;
            if (m_axi_awvalid) begin
                if (aw_wait >= aw_delay) begin
                    m_axi_awready = 1; aw_hs++; aw_wait = 0; aw_got = 1;
                    cap_awaddr = m_axi_awaddr; cap_awlen = m_axi_awlen; cap_awsize = m_axi_awsize;
                    cap_awburst = m_axi_awburst; cap_awid = m_axi_awid;
                end else aw_wait++;
            end
            m_axi_wready = 0;
            if (m_axi_wvalid) begin
                if (w_wait >= w_delay) begin
                    m_axi_wready = 1; w_hs++; w_wait = 0; w_got = 1;
                    cap_wdata = m_axi_wdata; cap_wstrb = m_axi_wstrb; cap_wlast = m_axi_wlast;
                end else w_wait++;
            end
            if (aw_got && w_got) begin
                b_pending = 1; b_wait = 0; aw_got = 0; w_got = 0;
            end
            if (o_mem_read_done || o_mem_write_done) begin
                done_kind.push_back(o_mem_write_done ? 1 : 0);
                done_cyc.push_back(c);
                done_err.push_back(o_bus_error);
                if (o_mem_read_done && o_mem_write_done) both++;
                if (o_mem_read_done) begin
                    cap_rdata = o_mem_read_data;
                    i_mem_read_req = 0;
                end
                if (o_mem_write_done) i_mem_write_valid = 0;
                seen++;
            end else if (o_bus_error) stray++;
        end
        repeat (2) begin
            @(negedge i_clk);
            if (o_mem_read_done || o_mem_write_done || o_bus_error) extra++;
        end
        check({tag, "_done_count"}, seen, n_done);
        check({tag, "_extra_pulses"}, extra + stray + both, 0);
    endtask

    task automatic do_read(input logic [63:0] addr, input int da, input int dr,
                           input logic [1:0] resp, input logic [255:0] data, input string tag);
        clear_log();
        ar_delay = da; r_delay = dr; rresp_cfg = resp; rdata_cfg = data;
        i_mem_read_address = addr;
        i_mem_read_req = 1;
        serve(1, 100, tag);
        if (done_kind.size() == 1) begin
            check({tag, "_kind"}, done_kind[0], 0);
            check({tag, "_latency"}, done_cyc[0], 3 + da + dr);
            check({tag, "_err"}, done_err[0], resp != 2'b00);
            check({tag, "_rdata"}, cap_rdata, data);
            check({tag, "_araddr"}, cap_araddr, addr & ~64'h1F);
            check({tag, "_ar_attr"}, {cap_arlen, cap_arsize, cap_arburst, cap_arid}, {8'd0, 3'd5, 2'd1, 4'd0});
            check({tag, "_ar_hs"}, ar_hs, 1);
            check({tag, "_no_aw"}, aw_hs + w_hs, 0);
        end
    endtask

    task automatic do_write(input logic [63:0] addr, input logic [63:0] data, input logic [7:0] strb,
                            input int daw, input int dw, input int db, input logic [1:0] resp,
                            input string tag);
        int lane;
        int exp_lat;
        clear_log();
        aw_delay = daw; w_delay = dw; b_delay = db; bresp_cfg = resp;
        i_mem_write_address = addr; i_mem_write_data = data; i_mem_write_strobe = strb;
        i_mem_write_valid = 1;
        serve(1, 100, tag);
        lane = int'(addr[4:3]);
        exp_lat = 3 + ((daw > dw) ? daw : dw) + db;
        if (done_kind.size() == 1) begin
            check({tag, "_kind"}, done_kind[0], 1);
            check({tag, "_latency"}, done_cyc[0], exp_lat);
            check({tag, "_err"}, done_err[0], resp != 2'b00);
            check({tag, "_awaddr"}, cap_awaddr, addr & ~64'h1F);
            check({tag, "_wdata"}, cap_wdata, {data, data, data, data});
            check({tag, "_wstrb"}, cap_wstrb, {24'd0, strb} << (lane * 8));
            check({tag, "_aw_attr"}, {cap_awlen, cap_awsize, cap_awburst, cap_awid, cap_wlast},
                  {8'd0, 3'd5, 2'd1, 4'd0, 1'b1});
            check({tag, "_hs"}, {aw_hs[7:0], w_hs[7:0], ar_hs[7:0]}, {8'd1, 8'd1, 8'd0});
        end
    endtask

    initial begin
        logic [63:0] ra;
        logic [63:0] rd;
        i_rst_n = 0;
        i_mem_read_req = 0; i_mem_read_address = '0;
        i_mem_write_valid = 0; i_mem_write_address = '0; i_mem_write_data = '0; i_mem_write_strobe = '0;
        ar_delay = 0; r_delay = 0; aw_delay = 0; w_delay = 0; b_delay = 0;
        rresp_cfg = 0; bresp_cfg = 0; rdata_cfg = '0;
        clear_slave();
        clear_log();
        repeat (3) @(negedge i_clk);
        check("reset_valids", {m_axi_arvalid, m_axi_awvalid, m_axi_wvalid, m_axi_rready, m_axi_bready}, 5'b0);
        check("reset_pulses", {o_mem_read_done, o_mem_write_done, o_bus_error}, 3'b0);
        check("reset_rdata", o_mem_read_data, 256'd0);
        i_rst_n = 1;

        do_read(64'h8000_0040, 0, 0, 2'b00, {32{8'hA5}}, "fill_a5");
        do_write(64'h1018, 64'h1122_3344_5566_7788, 8'h0F, 0, 0, 0, 2'b00, "wr_lane3");
        do_write(64'h2000_0008, 64'hDEAD_BEEF_0123_4567, 8'hF0, 5, 0, 1, 2'b00, "wr_aw_late");
        do_write(64'h2000_0030, 64'hCAFE_F00D_8899_AABB, 8'h3C, 0, 5, 0, 2'b00, "wr_w_late");

        clear_log();
        ar_delay = 0; r_delay = 0; aw_delay = 0; w_delay = 0; b_delay = 0;
        rresp_cfg = 0; bresp_cfg = 0; rdata_cfg = {8{32'h5A5A_0F0F}};
        i_mem_read_address = 64'h3000_0020; i_mem_read_req = 1;
        i_mem_write_address = 64'h4000_0010; i_mem_write_data = 64'h0102_0304_0506_0708;
        i_mem_write_strobe = 8'hFF; i_mem_write_valid = 1;
        serve(2, 200, "simul");
        if (done_kind.size() == 2) begin
            check("simul_order", {done_kind[0][0], done_kind[1][0]}, 2'b01);
            check("simul_cycles", {done_cyc[0][7:0], done_cyc[1][7:0]}, {8'd3, 8'd7});
            check("simul_rdata", cap_rdata, {8{32'h5A5A_0F0F}});
            check("simul_wstrb", cap_wstrb, 32'h00FF_0000);
        end

        do_read(64'h8000_1000, 1, 2, 2'b10, rand256(), "fill_slverr");
        do_write(64'h8000_1000, 64'h0, 8'h01, 0, 0, 2, 2'b11, "wr_decerr");

        clear_log();
        ar_delay = 1000;
        i_mem_read_address = 64'h2000; i_mem_read_req = 1;
        serve(0, 4, "stall");
        check("stall_arvalid", m_axi_arvalid, 1'b1);
        #2 i_rst_n = 0;
        #1;
        check("rst_mid_valids", {m_axi_arvalid, m_axi_awvalid, m_axi_wvalid, m_axi_rready, m_axi_bready}, 5'b0);
        check("rst_mid_pulses", {o_mem_read_done, o_mem_write_done, o_bus_error}, 3'b0);
        check("rst_mid_rdata", o_mem_read_data, 256'd0);
        i_mem_read_req = 0;
        clear_slave();
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1;
        do_read(64'h2000_0100, 0, 1, 2'b00, rand256(), "after_rst");

        for (int i = 0; i < 16; i++) begin
            ra = {$urandom(), $urandom()};
            rd = {$urandom(), $urandom()};
            if ($urandom_range(0, 1) == 0)
                do_read(ra, $urandom_range(0, 3), $urandom_range(0, 3),
                        ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00, rand256(), "rnd_rd");
            else
                do_write(ra, rd, 8'($urandom()), $urandom_range(0, 4), $urandom_range(0, 4),
                         $urandom_range(0, 3),
                         ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00, "rnd_wr");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/riscv_core_dcache_axi_bridge.md
# riscv_core_dcache_axi_bridge

Memory-side responder for the data-cache controller's line-fill and write-through interface. Accepts one line read (256-bit block fill) or one write-through store (64-bit data plus byte strobes) at a time, converts it to single-beat AXI4 master transactions, and returns a one-cycle done pulse. Sits between the dcache controller and the SoC AXI interconnect.

## Interface
Parameters:
- ADDR_WIDTH, 64, address width on both sides
- CORE_DATA_WIDTH, 64, write-through data width
- AXI_DATA_WIDTH, 256, AXI data width; equals one cache line
- AXI_ID_WIDTH, 4, AXI ID width
- AXI_ID, 0, constant ID driven on AR/AW

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - i_clk  in  1  clock
  - i_rst_n  in  1  asynchronous active-low reset
- Cache side, read:
  - i_mem_read_req  in  1  line fill request; held until done
  - i_mem_read_address  in  ADDR_WIDTH  line address, low 5 bits zero
  - o_mem_read_done  out  1  one-cycle pulse; line valid
  - o_mem_read_data  out  AXI_DATA_WIDTH  fetched line
- Cache side, write:
  - i_mem_write_valid  in  1  store request; held until done
  - i_mem_write_address  in  ADDR_WIDTH  byte address of the store
  - i_mem_write_data  in  CORE_DATA_WIDTH  store data
  - i_mem_write_strobe  in  8  byte enables within the 64-bit word
  - o_mem_write_done  out  1  one-cycle pulse
- Error:
  - o_bus_error  out  1  one-cycle pulse with done when RRESP/BRESP ≠ OKAY
- AXI AR/R:
  - m_axi_arvalid/arready  out/in  1 each
  - m_axi_araddr  out  ADDR_WIDTH
  - m_axi_arid  out  AXI_ID_WIDTH
  - m_axi_arlen  out  8, constant 0
  - m_axi_arsize  out  3, constant 3'b101
  - m_axi_arburst  out  2, constant INCR
  - m_axi_rvalid/rready  in/out  1 each
  - m_axi_rdata  in  AXI_DATA_WIDTH
  - m_axi_rresp  in  2
  - m_axi_rlast  in  1
- AXI AW/W/B:
  - m_axi_awvalid/awready, awaddr, awid, awlen, awsize, awburst: same encoding as AR
  - m_axi_wvalid/wready  out/in  1 each
  - m_axi_wdata  out  AXI_DATA_WIDTH
  - m_axi_wstrb  out  AXI_DATA_WIDTH/8
  - m_axi_wlast  out  1, constant 1
  - m_axi_bvalid/bready  in/out  1 each
  - m_axi_bresp  in  2

## Operation
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
- IDLE
  - i_mem_read_req has priority over i_mem_write_valid.
  - On read: latch address; go to RD_ADDR.
  - On write: latch address, data and strobe; go to WR_REQ.
- RD_ADDR
  - arvalid=1, araddr = latched address with [4:0] forced to 0.
  - On arready: go to RD_DATA.
- RD_DATA
  - rready=1.
  - On rvalid: register rdata into o_mem_read_data and record error = (rresp≠0); go to DONE.
  - rlast is ignored.
- WR_REQ
  - awvalid and wvalid are asserted together and tracked independently with aw_done/w_done flags; either channel may complete first.
  - awaddr = latched address with [4:0] forced to 0.
  - wdata = store data replicated into all four 64-bit lanes.
  - wstrb = strobe << (8 × addr[4:3]); all other strobe bits zero.
  - When both channels are done: go to WR_RESP.
- WR_RESP
  - bready=1.
  - On bvalid: record error = (bresp≠0); go to DONE.
- DONE
  - Pulse the matching done signal for exactly one cycle; o_bus_error pulses in the same cycle if an error was recorded.
  - Return to IDLE.
  - A new request present in the cycle after DONE is accepted normally.
- Requests never overlap: at most one AXI transaction is outstanding at any time.
- A request that drops before done has no effect. The latched transaction still completes, and its done pulse is produced and ignored.
- o_mem_read_data holds its last value until the next R handshake.

## Timing
- Reset values:
  - all AXI valid/ready outputs 0
  - o_mem_read_done, o_mem_write_done, o_bus_error: 0
  - o_mem_read_data: 0
  - state: IDLE; aw_done/w_done cleared
- All outputs are registered or decoded from registered state; there is no combinational path from any input to any output.
- Read, request seen in cycle N:
  - arvalid from N+1.
  - With arready at N+1 and rvalid at N+2, o_mem_read_done is high at N+3 (minimum latency 3).
- Write, request seen in cycle N:
  - awvalid/wvalid from N+1.
  - With aw/w accepted at N+1 and bvalid at N+2, o_mem_write_done is high at N+3.
- Reset asserted mid-transaction: all valids drop immediately and no done pulse is issued. Recovery of the interconnect is the system's responsibility.

## Structure
- Shared package riscv_core_dcache_pkg holds:
  - state enum
  - AXI constants (AXI_RESP_OKAY, AXI_BURST_INCR, AXI_SIZE_32B)
  - LINE_OFFSET_BITS = 5
- One sub-module, riscv_core_dcache_wlane_align: combinational lane replication and strobe shift (addr[4:3], data, strobe → wdata, wstrb).

## Test plan
- Read fill: req addr 0x8000_0040, arready immediate, rdata=0xA5…A5 one cycle later → araddr 0x8000_0040, arlen 0, arsize 5, done at N+3 with data 0xA5…A5, o_bus_error=0.
- Write lane placement: addr 0x1018, data 0x1122334455667788, strobe 0x0F → awaddr 0x1000, wstrb 0x0F000000, every wdata lane 0x1122334455667788, done after B.
- AW/W skew: awready delayed 5 cycles while wready is immediate, and the reverse → wvalid drops after its handshake, a single B wait, exactly one write done pulse.
- Simultaneous read and write requests in IDLE → read serviced first, write serviced right after, two distinct done pulses in that order.
- Error response: rresp=SLVERR on a fill, then bresp=DECERR on a store → o_bus_error pulses together with each done.
- Reset mid-transaction: i_rst_n low while arvalid=1 and stalled → all outputs return to their reset values asynchronously; after release, a new read completes normally.
